// File: rtl/imem_loadable_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  // Controller states: serve fetches, accept loader bytes, write a partial word.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Value returned on a faulting fetch (sll $0,$0,0).
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Default text-segment base: byte address of RAM word 0.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

endpackage

// File: rtl/imem_loadable_if.sv
// Loader byte stream and fetch port of the instruction memory.
// master = loader/PC-stage side, slave = memory side.
interface imem_loadable_if #(
  parameter int ADDR_W = 11
) ();

  // Loader side
  logic              ld_start;
  logic              ld_byte_valid;
  logic [7:0]        ld_byte;
  logic              ld_byte_ready;
  logic              ld_done;
  logic              loading;
  logic [ADDR_W:0]   ld_count;
  logic              ld_overflow;

  // Fetch side
  logic              if_req;
  logic [31:0]       if_pc;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic              if_fault;

  modport master (
    output ld_start, ld_byte_valid, ld_byte, ld_done, if_req, if_pc,
    input  ld_byte_ready, loading, ld_count, ld_overflow,
           if_valid, if_instr, if_fault
  );

  modport slave (
    input  ld_start, ld_byte_valid, ld_byte, ld_done, if_req, if_pc,
    output ld_byte_ready, loading, ld_count, ld_overflow,
           if_valid, if_instr, if_fault
  );

endinterface

// File: rtl/imem_loadable_ram.sv
// Simple dual-port synchronous RAM, 32-bit words, read-first on a
// same-address collision, no reset so it maps onto block RAM.
module imem_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];
  logic [31:0] r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; sees the array before this edge's write (read-first).
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: byte-stream loader FSM, byte
// assembler, PC-to-word translation with fault detection, and one-cycle
// registered fetch response.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input logic          clk,
  input logic          rst_n,
  imem_loadable_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  // Bytes covered by the RAM; offsets at or above this are out of range.
  localparam logic [32:0]     FETCH_SPAN = 33'd4 << ADDR_W;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_loading;
  logic              w_ld_byte_ready;

  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_hold;
  logic [ADDR_W:0]   r_ld_count;
  logic              r_overflow;

  logic              w_full;
  logic              w_take;
  logic              w_word_done;
  logic              w_flush;
  logic              w_restart;
  logic [1:0]        w_byte_cnt_after;
  logic              w_we;
  logic [31:0]       w_wdata;

  logic [31:0]       w_off;
  logic              w_fault;
  logic              w_accept;
  logic              w_re;
  logic [31:0]       w_rdata;

  logic              r_if_valid;
  logic              r_if_fault;

  // Loader bookkeeping. The top bit of ld_count marks a completely filled
  // RAM; any byte seen then is dropped and flagged as overflow.
  assign w_full      = r_ld_count[ADDR_W];
  // A restart in LOAD discards any byte offered in the same cycle.
  assign w_take      = (r_state == LOAD) && bus.ld_byte_valid && !bus.ld_start;
  assign w_word_done = w_take && !w_full && (r_byte_cnt == 2'd3);
  assign w_flush     = (r_state == FLUSH);
  // A start pulse during the single FLUSH cycle is ignored (loading is high).
  assign w_restart   = bus.ld_start && (r_state != FLUSH);
  // Pending-byte count including a byte taken this cycle, so a done pulse
  // alongside the last byte sees it.
  assign w_byte_cnt_after = (w_take && !w_full) ? r_byte_cnt + 2'd1 : r_byte_cnt;

  assign w_we    = w_word_done || w_flush;
  // Unfilled lanes of r_hold are always zero, so a flush pads for free.
  assign w_wdata = w_flush ? {8'h00, r_hold} : {bus.ld_byte, r_hold};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded loader outputs.
  always_comb begin
    w_state_next    = r_state;
    w_loading       = 1'b0;
    w_ld_byte_ready = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.ld_start) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_loading       = 1'b1;
        w_ld_byte_ready = 1'b1;
        if (bus.ld_start) begin
          w_state_next = LOAD;
        end else if (bus.ld_done) begin
          w_state_next = (w_byte_cnt_after != 2'd0) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        w_loading    = 1'b1;
        w_state_next = RUN;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // Byte assembler: lane-indexed holding register, word counter, overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_hold     <= 24'h0;
      r_ld_count <= '0;
      r_overflow <= 1'b0;
    end else if (w_restart) begin
      r_byte_cnt <= 2'd0;
      r_hold     <= 24'h0;
      r_ld_count <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_byte_cnt <= 2'd0;
      r_hold     <= 24'h0;
      r_ld_count <= r_ld_count + CNT_ONE;
    end else if (w_take) begin
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_hold        <= {16'h0000, bus.ld_byte};
          2'd1:    r_hold[15:8]  <= bus.ld_byte;
          2'd2:    r_hold[23:16] <= bus.ld_byte;
          default: begin
            r_hold     <= 24'h0;
            r_ld_count <= r_ld_count + CNT_ONE;
          end
        endcase
      end
    end
  end

  // Address translation. A PC below the base wraps to a huge offset, but it
  // is tested explicitly so the intent stays readable.
  assign w_off    = bus.if_pc - BASE_ADDR;
  assign w_fault  = (bus.if_pc < BASE_ADDR) ||
                    ({1'b0, w_off} >= FETCH_SPAN) ||
                    (bus.if_pc[1:0] != 2'b00);
  // Fetches are only served in RUN; a start pulse in the same cycle still
  // sees RUN, so that fetch reads the old contents.
  assign w_accept = bus.if_req && (r_state == RUN);
  assign w_re     = w_accept && !w_fault;

  imem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_ld_count[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_off[ADDR_W+1:2]),
    .o_rdata (w_rdata)
  );

  // Fetch response qualifiers, one cycle behind the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_fault <= 1'b0;
    end else begin
      r_if_valid <= w_accept;
      r_if_fault <= w_accept && w_fault;
    end
  end

  // The RAM output register holds stale data when idle or faulting, so
  // the instruction is forced to NOP unless a good fetch completed.
  assign bus.if_instr      = (r_if_valid && !r_if_fault) ? w_rdata : MIPS_NOP;
  assign bus.if_valid      = r_if_valid;
  assign bus.if_fault      = r_if_fault;
  assign bus.loading       = w_loading;
  assign bus.ld_byte_ready = w_ld_byte_ready;
  assign bus.ld_count      = r_ld_count;
  assign bus.ld_overflow   = r_overflow;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: hand sequences for the loader corner cases, a
// table of fetch vectors, randomized loads/fetches against a byte-list
// reference model, an ADDR_W=2 instance for overflow, and a direct RAM
// collision check.
module tb_imem_loadable;
  import imem_pkg::*;

  localparam int          AW_A    = 11;
  localparam int          AW_B    = 2;
  localparam int          DEPTH_A = 1 << AW_A;
  localparam logic [31:0] BASE    = 32'h0040_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  imem_loadable_if #(.ADDR_W(AW_A)) a ();
  imem_loadable_if #(.ADDR_W(AW_B)) b ();

  imem_loadable #(.ADDR_W(AW_A), .BASE_ADDR(BASE)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (a.slave)
  );
  imem_loadable #(.ADDR_W(AW_B), .BASE_ADDR(BASE)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (b.slave)
  );

  logic        ram_we, ram_re;
  logic [3:0]  ram_waddr, ram_raddr;
  logic [31:0] ram_wdata, ram_rdata;

  imem_ram #(.ADDR_W(4)) u_ram (
    .clk (clk), .i_we (ram_we), .i_waddr (ram_waddr), .i_wdata (ram_wdata),
    .i_re (ram_re), .i_raddr (ram_raddr), .o_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: memory image built from the byte stream by plain packing.
  logic [31:0] model_mem [0:DEPTH_A-1];
  int          model_hi = 0;

  typedef struct {
    logic [31:0] pc;
    bit          fault;
    logic [31:0] instr;
    string       name;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_load(input logic [7:0] bytes[$]);
    int n;
    int words;
    logic [31:0] v;
    n = bytes.size();
    words = (n + 3) / 4;
    if (words > DEPTH_A) words = DEPTH_A;
    for (int w = 0; w < words; w++) begin
      v = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) v[8*k +: 8] = bytes[4*w + k];
      model_mem[w] = v;
    end
    if (words > model_hi) model_hi = words;
  endfunction

  function automatic void ref_fetch(input logic [31:0] pc, output bit f, output logic [31:0] w);
    longint unsigned upc;
    longint unsigned ubase;
    upc = pc;
    ubase = BASE;
    if (upc < ubase || upc >= ubase + 4 * DEPTH_A || (upc % 4) != 0) begin
      f = 1'b1;
      w = MIPS_NOP;
    end else begin
      f = 1'b0;
      w = model_mem[int'((upc - ubase) / 4)];
    end
  endfunction

  task automatic a_byte(input logic [7:0] v);
    a.ld_byte_valid = 1'b1;
    a.ld_byte = v;
    cyc();
    a.ld_byte_valid = 1'b0;
  endtask

  // Full load on instance A; 'extra' = cycles loading stayed high after the done edge.
  task automatic a_load(input logic [7:0] bytes[$], input bit gaps, input bit done_with_last,
                        input string tag, output int extra);
    int exp_cnt;
    a.ld_start = 1'b1;
    cyc();
    a.ld_start = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc();
      if (done_with_last && i == bytes.size() - 1) a.ld_done = 1'b1;
      a_byte(bytes[i]);
    end
    if (!(done_with_last && bytes.size() > 0)) begin
      a.ld_done = 1'b1;
      cyc();
    end
    a.ld_done = 1'b0;
    extra = 0;
    while (a.loading === 1'b1 && extra < 8) begin
      cyc();
      extra++;
    end
    check($sformatf("%s loading", tag), {31'b0, a.loading}, 32'h0);
    model_load(bytes);
    exp_cnt = (bytes.size() + 3) / 4;
    check($sformatf("%s ld_count", tag), {20'b0, a.ld_count}, exp_cnt);
    $display("load %s: %0d bytes ld_count=%0d extra=%0d", tag, bytes.size(), a.ld_count, extra);
  endtask

  task automatic a_fetch(input logic [31:0] pc, input bit exp_f, input logic [31:0] exp_w,
                         input string tag);
    a.if_req = 1'b1;
    a.if_pc = pc;
    cyc();
    a.if_req = 1'b0;
    check($sformatf("%s valid", tag), {31'b0, a.if_valid}, 32'h1);
    check($sformatf("%s fault", tag), {31'b0, a.if_fault}, {31'b0, exp_f});
    check($sformatf("%s instr", tag), a.if_instr, exp_w);
    $display("fetch %s: pc=%h instr=%h fault=%0b", tag, pc, a.if_instr, a.if_fault);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] t1_bytes [8] = '{8'h0C, 8'h00, 8'h08, 8'h20, 8'h01, 8'h00, 8'h09, 8'h24};
    logic [7:0] t2_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int extra;
    bit f;
    logic [31:0] w;
    logic [31:0] pc;
    int idx;

    a.ld_start = 0; a.ld_byte_valid = 0; a.ld_byte = 0; a.ld_done = 0; a.if_req = 0; a.if_pc = 0;
    b.ld_start = 0; b.ld_byte_valid = 0; b.ld_byte = 0; b.ld_done = 0; b.if_req = 0; b.if_pc = 0;
    ram_we = 0; ram_re = 0; ram_waddr = 0; ram_raddr = 0; ram_wdata = 0;

    // Reset state
    repeat (3) cyc();
    check("rst loading",  {31'b0, a.loading},       32'h0);
    check("rst ready",    {31'b0, a.ld_byte_ready}, 32'h0);
    check("rst ld_count", {20'b0, a.ld_count},      32'h0);
    check("rst overflow", {31'b0, a.ld_overflow},   32'h0);
    check("rst if_valid", {31'b0, a.if_valid},      32'h0);
    check("rst if_instr", a.if_instr,               32'h0);
    check("rst if_fault", {31'b0, a.if_fault},      32'h0);
    rst_n = 1'b1;
    cyc();

    // Two full words, done with nothing pending
    q.delete();
    foreach (t1_bytes[i]) q.push_back(t1_bytes[i]);
    a_load(q, 1'b0, 1'b0, "t1", extra);
    check("t1 done latency", extra, 32'd0);
    a_fetch(BASE,      1'b0, 32'h2008000C, "t1 w0");
    a_fetch(BASE + 4,  1'b0, 32'h24090001, "t1 w1");
    cyc();
    check("idle if_valid", {31'b0, a.if_valid}, 32'h0);

    // One word plus one pending byte: goes through FLUSH
    q.delete();
    foreach (t2_bytes[i]) q.push_back(t2_bytes[i]);
    a_load(q, 1'b0, 1'b0, "t2", extra);
    check("t2 flush latency", extra, 32'd1);

    // Fetch vector table
    vecs[0] = '{BASE,          1'b0, 32'h44332211, "tbl w0"};
    vecs[1] = '{BASE + 4,      1'b0, 32'h00000055, "tbl w1 flushed"};
    vecs[2] = '{32'h003FFFFC,  1'b1, 32'h0,        "tbl below base"};
    vecs[3] = '{32'h00402000,  1'b1, 32'h0,        "tbl past end"};
    vecs[4] = '{32'h00400002,  1'b1, 32'h0,        "tbl misaligned"};
    vecs[5] = '{32'h00000000,  1'b1, 32'h0,        "tbl zero pc"};
    for (int i = 0; i < 6; i++) a_fetch(vecs[i].pc, vecs[i].fault, vecs[i].instr, vecs[i].name);

    // Done together with the last byte: 4 bytes -> straight to RUN, 5 -> FLUSH
    q = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    a_load(q, 1'b0, 1'b1, "same4", extra);
    check("same4 latency", extra, 32'd0);
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    a_load(q, 1'b0, 1'b1, "same5", extra);
    check("same5 latency", extra, 32'd1);
    ref_fetch(BASE + 4, f, w);
    a_fetch(BASE + 4, f, w, "same5 w1");

    // Restart in LOAD discards the pending bytes
    a.ld_start = 1'b1; cyc(); a.ld_start = 1'b0;
    a_byte(8'h77); a_byte(8'h66); a_byte(8'h55);
    a.ld_start = 1'b1; cyc(); a.ld_start = 1'b0;
    check("restart ld_count", {20'b0, a.ld_count}, 32'h0);
    check("restart loading",  {31'b0, a.loading},  32'h1);
    a_byte(8'h10); a_byte(8'h20); a_byte(8'h30); a_byte(8'h40);
    a.ld_done = 1'b1; cyc(); a.ld_done = 0;
    check("restart end ld_count", {20'b0, a.ld_count}, 32'h1);
    q = {8'h10, 8'h20, 8'h30, 8'h40};
    model_load(q);
    a_fetch(BASE, 1'b0, 32'h40302010, "restart w0");

    // Fetch coinciding with ld_start in RUN reads old contents
    a.ld_start = 1'b1; a.if_req = 1'b1; a.if_pc = BASE;
    cyc();
    a.ld_start = 1'b0; a.if_req = 1'b0;
    check("start+fetch valid", {31'b0, a.if_valid}, 32'h1);
    check("start+fetch instr", a.if_instr, 32'h40302010);
    check("start+fetch loading", {31'b0, a.loading}, 32'h1);

    // Fetches during LOAD are dropped, including the cycle the 4th byte lands
    a.if_req = 1'b1; a.if_pc = BASE;
    a_byte(8'hA1); check("load fetch 1", {31'b0, a.if_valid}, 32'h0);
    a_byte(8'hB2); check("load fetch 2", {31'b0, a.if_valid}, 32'h0);
    a_byte(8'hC3); check("load fetch 3", {31'b0, a.if_valid}, 32'h0);
    a_byte(8'hD4); check("load fetch 4", {31'b0, a.if_valid}, 32'h0);
    a.if_req = 1'b0;
    a_byte(8'hE5); a_byte(8'hF6);
    // Reset mid-load: control returns to RUN, written word survives
    rst_n = 1'b0;
    cyc();
    check("midrst loading",  {31'b0, a.loading},  32'h0);
    check("midrst ld_count", {20'b0, a.ld_count}, 32'h0);
    rst_n = 1'b1;
    cyc();
    q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    model_load(q);
    a_fetch(BASE, 1'b0, 32'hD4C3B2A1, "midrst w0");
    ref_fetch(BASE + 4, f, w);
    a_fetch(BASE + 4, f, w, "midrst w1");

    // Randomized loads and back-to-back fetches against the model
    for (int r = 0; r < 6; r++) begin
      q.delete();
      repeat ($urandom_range(0, 40)) q.push_back(8'($urandom));
      a_load(q, 1'b1, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r), extra);
    end
    for (int i = 0; i < 120; i++) begin
      idx = $urandom_range(0, model_hi - 1);
      case ($urandom_range(0, 5))
        0, 1, 2: pc = BASE + 32'(4 * idx);
        3:       pc = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
        4:       pc = 32'($urandom_range(0, 32'h003F_FFFF));
        default: pc = BASE + 32'(4 * DEPTH_A) + 32'($urandom_range(0, 32'h00FF_FFFF));
      endcase
      a.if_req = ($urandom_range(0, 3) != 0);
      a.if_pc = pc;
      ref_fetch(pc, f, w);
      cyc();
      check($sformatf("rnd%0d valid", i), {31'b0, a.if_valid}, {31'b0, a.if_req});
      if (a.if_req) begin
        check($sformatf("rnd%0d fault", i), {31'b0, a.if_fault}, {31'b0, f});
        check($sformatf("rnd%0d instr", i), a.if_instr, w);
        $display("rfetch %0d: pc=%h instr=%h fault=%0b", i, pc, a.if_instr, a.if_fault);
      end
    end
    a.if_req = 1'b0;

    // ADDR_W=2 instance: 20 bytes into a 4-word RAM
    b.ld_start = 1'b1; cyc(); b.ld_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b.ld_byte_valid = 1'b1;
      b.ld_byte = 8'(i + 1);
      cyc();
      if (i == 15) begin
        check("ovf at full count", {29'b0, b.ld_count}, 32'd4);
        check("ovf not yet",       {31'b0, b.ld_overflow}, 32'h0);
      end
    end
    b.ld_byte_valid = 1'b0;
    b.ld_done = 1'b1; cyc(); b.ld_done = 1'b0;
    check("ovf ld_count", {29'b0, b.ld_count},    32'd4);
    check("ovf flag",     {31'b0, b.ld_overflow}, 32'h1);
    check("ovf loading",  {31'b0, b.loading},     32'h0);
    b.if_req = 1'b1; b.if_pc = BASE + 12; cyc();
    check("ovf last word", b.if_instr, 32'h100F0E0D);
    b.if_pc = BASE + 16; cyc();
    b.if_req = 1'b0;
    check("ovf past end fault", {31'b0, b.if_fault}, 32'h1);
    b.ld_start = 1'b1; cyc(); b.ld_start = 1'b0;
    check("ovf clr flag",  {31'b0, b.ld_overflow}, 32'h0);
    check("ovf clr count", {29'b0, b.ld_count},    32'h0);
    b.ld_done = 1'b1; cyc(); b.ld_done = 1'b0;
    $display("load ovf: ld_count=%0d overflow=%0b", b.ld_count, b.ld_overflow);

    // RAM collision: same-edge write and read of one address returns old data
    ram_we = 1'b1; ram_waddr = 4'd5; ram_wdata = 32'hAAAA0000; cyc();
    ram_wdata = 32'hBBBB1111; ram_re = 1'b1; ram_raddr = 4'd5; cyc();
    ram_we = 1'b0;
    check("ram read-first old", ram_rdata, 32'hAAAA0000);
    cyc();
    ram_re = 1'b0;
    check("ram read-first new", ram_rdata, 32'hBBBB1111);
    $display("ram collision: rdata=%h", ram_rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
